binary_to_bcd: RTL and testbench
================================

# binary_to_bcd

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock. It accepts a 14-bit unsigned binary value on a valid/ready input handshake and returns four packed BCD digits on a valid/ready output handshake. It is the return path paired with the team's 4-digit BCD-to-binary converter, and it feeds display and decimal-report logic.

## Interface
- `BIN_W`, 14: binary input width.
- `DIGITS`, 4: number of BCD output digits. The output width is 4*DIGITS.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bin` input BIN_W: unsigned binary operand, sampled when `in_valid & in_ready`.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: converter idle and able to accept an operand.
- `bcd` output 4*DIGITS: packed BCD result; digit 0 is in `bcd[3:0]`.
- `err` output 1: the operand exceeded MAX = 10^DIGITS − 1. Valid with `out_valid`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `bin` into the shift register, clear the BCD accumulator, set bit counter = BIN_W, compute the range flag (`bin` > MAX), then go to SHIFT.
- **SHIFT**
  - Each cycle, every 4-bit accumulator digit ≥ 5 gets +3.
  - The combined {accumulator, shift register} then shifts left by 1 and the counter decrements.
  - After the BIN_W-th shift, go to DONE.
  - `in_ready`=0. `in_valid` is ignored.
- **DONE**
  - `out_valid`=1.
  - `bcd` and `err` are held stable until `out_valid & out_ready`, then return to IDLE.
  - `in_ready`=0. There is no accept in the same cycle as the output handshake.
- Arithmetic rules:
  - Digit adjust is 4-bit with no carry out of the digit; a value ≥ 5 plus 3 never exceeds 4'hF before the shift.
  - Bits shifted out of the top digit are discarded.
  - Without saturation, the result therefore equals `bin` mod 10^DIGITS.
- Reset values:
  - State = IDLE, so `in_ready`=1 once `rst_n` is high.
  - `out_valid`=0, `bcd`=0, `err`=0, counter=0.
- Reset asserted mid-conversion aborts the operation. No `out_valid` pulse is produced and the block returns to IDLE.
- Operand 0 and operand MAX are legal boundary values and give `err`=0.

## Timing
- Acceptance edge is T.
- Shifts happen on edges T+1 through T+BIN_W.
- `out_valid` rises after edge T+BIN_W, i.e. 14 cycles of latency at default parameters.
- Throughput is one conversion per BIN_W+2 cycles at best (accept, BIN_W shifts, output handshake).
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from the inputs.
- Outputs `bcd` and `err` are registered.

## Configuration
- `BIN2BCD_SAT_EN` defined:
  - An out-of-range operand still takes the full BIN_W cycles.
  - In DONE, `bcd` is forced to all 4'h9 digits and `err`=1.
- `BIN2BCD_SAT_EN` undefined:
  - `bcd` = `bin` mod 10^DIGITS, with `err`=1 for out-of-range operands.
  - The saturation mux is absent.
- The range flag and `err` exist in both builds.

## Structure
- Package `bcd_pkg`:
  - State enum (IDLE/SHIFT/DONE).
  - Digit width constant (4).
  - Default DIGITS.
  - Constant function giving 10^DIGITS − 1, shared with the BCD-to-binary side for range checks.
- Sub-module `bcd_digit_adj`:
  - Combinational 4-bit "add 3 if ≥ 5".
  - Instantiated DIGITS times in a generate loop.
- Top level holds the FSM, bit counter, shift registers, range flag and output registers.

## Test plan
- After reset, `bin`=0 → `bcd`=16'h0000, `err`=0, `out_valid` exactly 14 cycles after acceptance. Also check the reset values of every output.
- `bin`=1234 → 16'h1234. `bin`=9999 → 16'h9999 with `err`=0. Back-to-back operands 7 and 4095 → 16'h0007, then 16'h4095.
- `bin`=12345 → `err`=1.
  - With `BIN2BCD_SAT_EN`: `bcd`=16'h9999.
  - Without it: `bcd`=16'h2345.
  - `bin`=16383 → `err`=1, and without the macro `bcd`=16'h6383.
- Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and `bin`:
  - `bcd`/`err` stay stable, `in_ready` stays 0 and no new operand is captured.
  - Raising `out_ready` gives one handshake, then `in_ready`=1 on the next cycle.
- Pulse `rst_n` low asynchronously 7 cycles into a conversion of 5678:
  - `out_valid` stays 0 and `bcd`=0.
  - After release, `in_ready`=1 and a fresh 5678 → 16'h5678.
- Random sweep of 0..16383 against a `bin` mod 10000 (or saturated) reference model, checking the 14-cycle latency on every operand.

Source files
------------

// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the binary<->BCD converter pair.
//   state_e         : converter FSM states (IDLE / SHIFT / DONE)
//   DIGIT_W         : width of one packed BCD digit
//   DEFAULT_DIGITS  : default number of BCD digits
//   bcd_max(digits) : largest value representable in 'digits' BCD digits,
//                     i.e. 10^digits - 1; used for range checks on both sides
// ----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W        = 4;
  localparam int DEFAULT_DIGITS = 4;

  function automatic int bcd_max(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: adds 3 to a BCD digit that is
// 5 or more, so that the following left shift carries correctly into the next
// decimal digit. The result never exceeds 4'hC, so no carry out is needed.
//   digit_i : current 4-bit accumulator digit
//   digit_o : corrected digit, ready to be shifted
// ----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/binary_to_bcd.sv
// ----------------------------------------------------------------------------
// binary_to_bcd
// Sequential binary-to-BCD converter (shift-add-3), one operand bit per clock.
// Optional build macro: BIN2BCD_SAT_EN -- when defined, an out-of-range
// operand returns all-9 digits instead of bin mod 10^DIGITS.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bin        : unsigned operand, sampled on in_valid & in_ready
//   in_valid   : operand valid
//   in_ready   : converter idle, operand will be accepted
//   bcd        : packed BCD result, digit 0 in bcd[3:0] (registered)
//   err        : operand exceeded 10^DIGITS - 1 (registered, valid with out_valid)
//   out_valid  : result valid, held until out_ready
//   out_ready  : downstream accepts the result
// ----------------------------------------------------------------------------
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIN_W-1:0]          bin,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int          BCD_W   = DIGIT_W * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(bcd_max(DIGITS));

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sreg_q, sreg_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               range_q, range_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic [BCD_W-1:0]   result;
  logic [31:0]        bin_ext;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (acc_q[gi*DIGIT_W +: DIGIT_W]),
        .digit_o (acc_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Shift {acc, sreg} left by one; the bit leaving the top digit is dropped,
  // which is what makes an oversized operand wrap to bin mod 10^DIGITS.
  assign acc_shift = BCD_W'({acc_adj, sreg_q[BIN_W-1]});

`ifdef BIN2BCD_SAT_EN
  assign result = range_q ? {DIGITS{4'h9}} : acc_shift;
`else
  assign result = acc_shift;
`endif

  assign bin_ext = 32'(bin);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    range_d = range_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_d  = bin;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          range_d = (bin_ext > MAX_VAL);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d  = acc_shift;
        sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        // Final shift: load the output registers with the post-shift value
        // so bcd/err are already stable when out_valid rises.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = result;
          err_d   = range_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      range_q <= 1'b0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      range_q <= range_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;
  assign err       = err_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

  localparam int LATENCY = 14;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  binary_to_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] exp_bcd;
    logic        exp_err;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: decimal digits of v mod 10000 (or all nines if saturating).
  function automatic logic [15:0] model_bcd(input int v);
    int m;
    logic [15:0] r;
`ifdef BIN2BCD_SAT_EN
    m = (v > 9999) ? 9999 : v;
`else
    m = v % 10000;
`endif
    r[3:0]   = 4'(m % 10);
    r[7:4]   = 4'((m / 10) % 10);
    r[11:8]  = 4'((m / 100) % 10);
    r[15:12] = 4'((m / 1000) % 10);
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        prev_ov = 1'b0;
  logic [15:0] held_bcd;
  logic        held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          if (!prev_ov) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=bcd %h required=no output", bcd);
          end
        end else begin
          if (!prev_ov) begin
            chk("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(LATENCY));
            held_bcd = bcd;
            held_err = err;
          end else begin
            chk("hold_bcd", 32'(bcd), 32'(held_bcd));
            chk("hold_err", 32'(err), 32'(held_err));
          end
          if (out_ready) begin
            chk("bcd", 32'(bcd), 32'(sb_q[0].exp_bcd));
            chk("err", 32'(err), 32'(sb_q[0].exp_err));
            $display("txn cyc=%0d bcd=%h err=%0b exp_bcd=%h exp_err=%0b",
                     cyc, bcd, err, sb_q[0].exp_bcd, sb_q[0].exp_err);
            void'(sb_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called positioned just after a rising edge; returns just after the
  // acceptance edge with in_valid dropped.
  task automatic send(input int v, input logic [15:0] eb, input logic ee);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bin      = 14'(v);
    in_valid = 1'b1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready 0 required=1 (bin=%0d)", v);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.exp_bcd = eb;
    e.exp_err = ee;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input int v);
    send(v, model_bcd(v), (v > 9999));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    rst_n     = 1'b0;
    bin       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors
    send(0, 16'h0000, 1'b0);
    send(1234, 16'h1234, 1'b0);
    send(9999, 16'h9999, 1'b0);
    send(7, 16'h0007, 1'b0);
    send(4095, 16'h4095, 1'b0);
`ifdef BIN2BCD_SAT_EN
    send(12345, 16'h9999, 1'b1);
    send(16383, 16'h9999, 1'b1);
`else
    send(12345, 16'h2345, 1'b1);
    send(16383, 16'h6383, 1'b1);
`endif
    drain();

    // Backpressure: hold the result while in_valid/bin wiggle
    out_ready = 1'b0;
    send(4321, 16'h4321, 1'b0);
    seen = 1'b0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_out_valid_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      bin      = 14'($urandom_range(0, 16383));
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_queue", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a conversion
    bin      = 14'd5678;
    in_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send(5678, 16'h5678, 1'b0);
    drain();

    // Sweep with reference model
    for (int n = 0; n < 24; n++) begin
      send_model(int'($urandom_range(0, 16383)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
